// File: rtl/serial_line_tx.sv
// Asynchronous-frame serializer: start bit, DATA_W data bits LSB first, stop bit.
// The serial pin is driven directly from a flop so it cannot glitch.
module serial_line_tx #(
  parameter int DATA_W       = 8,
  parameter int CLKS_PER_BIT = 16
) (
  input  logic              i_clk,
  input  logic              i_rstn,
  input  logic [DATA_W-1:0] i_txData,
  input  logic              i_txValid,
  output logic              o_txReady,
  output logic              o_serialLine,
  output logic              o_busy
);

  localparam int TMR_W = $clog2(CLKS_PER_BIT);
  localparam int IDX_W = $clog2(DATA_W) + 1;
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_W - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
  } state_e;

  state_e              state_q, state_d;
  logic [TMR_W-1:0]    timer_q, timer_d;
  logic [IDX_W-1:0]    idx_q,   idx_d;
  logic [DATA_W-1:0]   shift_q, shift_d;
  logic                line_q,  line_d;

  logic accept;
  logic bit_done;

  assign accept   = (state_q == S_IDLE) && i_txValid;
  assign bit_done = (timer_q == TMR_LAST);

  always_comb begin
    // NOTE: every _d gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    state_d = state_q;
    timer_d = timer_q;
    idx_d   = idx_q;
    shift_d = shift_q;

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          state_d = S_START;
          timer_d = '0;
          idx_d   = '0;
          shift_d = i_txData;
        end
      end

      S_START: begin
        if (bit_done) begin
          state_d = S_DATA;
          timer_d = '0;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end

      S_DATA: begin
        if (bit_done) begin
          timer_d = '0;
          shift_d = shift_q >> 1;
          idx_d   = idx_q + 1'b1;
          if (idx_q == IDX_LAST) begin
            state_d = S_STOP;
          end
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end

      S_STOP: begin
        if (bit_done) begin
          state_d = S_IDLE;
          timer_d = '0;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end

      default: begin
        state_d = S_IDLE;
        timer_d = '0;
      end
    endcase
  end

  // The line level is decoded from the *next* state so the registered pin
  // lines up exactly with the state it belongs to: low right after accept.
  always_comb begin
    line_d = 1'b1;
    case (state_d)
      S_START: line_d = 1'b0;
      S_DATA:  line_d = shift_d[0];
      default: line_d = 1'b1;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state_q <= S_IDLE;
      timer_q <= '0;
      idx_q   <= '0;
      // NOTE: the data shift register is reset with the control state so a
      // fresh part never has stale contents on its first frame.
      shift_q <= '0;
      line_q  <= 1'b1;
    end else begin
      // NOTE: non-blocking assignments so every flop updates from the
      // pre-edge values of the others.
      state_q <= state_d;
      timer_q <= timer_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      line_q  <= line_d;
    end
  end

  assign o_serialLine = line_q;
  assign o_txReady    = (state_q == S_IDLE);
  assign o_busy       = (state_q != S_IDLE);

endmodule

// File: tb/tb_serial_line_tx.sv
// Scoreboard bench for serial_line_tx: stimulus queues expected words, a
// per-DUT monitor decodes every frame on the pin and checks it.
module tb_serial_line_tx;

  localparam int DW_A  = 8;
  localparam int CPB_A = 4;
  localparam int DW_B  = 5;
  localparam int CPB_B = 2;

  logic       clk;
  logic       rst_n;
  logic [7:0] data_a;
  logic       valid_a, ready_a, line_a, busy_a;
  logic [4:0] data_b;
  logic       valid_b, ready_b, line_b, busy_b;

  typedef struct {
    logic [15:0] data;
    int          gap;   // required idle cycles before this frame, -1 = don't care
  } exp_t;

  exp_t q_a[$];
  exp_t q_b[$];

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  serial_line_tx #(.DATA_W(DW_A), .CLKS_PER_BIT(CPB_A)) dut_a (
    .i_clk(clk), .i_rstn(rst_n), .i_txData(data_a), .i_txValid(valid_a),
    .o_txReady(ready_a), .o_serialLine(line_a), .o_busy(busy_a)
  );

  serial_line_tx #(.DATA_W(DW_B), .CLKS_PER_BIT(CPB_B)) dut_b (
    .i_clk(clk), .i_rstn(rst_n), .i_txData(data_b), .i_txValid(valid_b),
    .o_txReady(ready_b), .o_serialLine(line_b), .o_busy(busy_b)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic get_line(input int w);
    return (w == 0) ? line_a : line_b;
  endfunction

  function automatic logic get_ready(input int w);
    return (w == 0) ? ready_a : ready_b;
  endfunction

  function automatic logic get_busy(input int w);
    return (w == 0) ? busy_a : busy_b;
  endfunction

  function automatic int get_qsize(input int w);
    return (w == 0) ? q_a.size() : q_b.size();
  endfunction

  // Decodes one frame per falling line edge; a reset during the frame abandons it.
  task automatic run_monitor(input int w, input int dw, input int cpb);
    logic        samp [0:287];
    logic [15:0] word;
    int          last_end;
    int          start_cyc;
    int          n;
    bit          aborted, uniform, ready_low, busy_high;
    exp_t        e;
    string       p;
    p        = (w == 0) ? "a" : "b";
    last_end = -1;
    forever begin
      @(negedge clk);
      if (rst_n && get_line(w) == 1'b0) begin
        n         = (dw + 2) * cpb;
        start_cyc = cyc;
        aborted   = 1'b0;
        ready_low = 1'b1;
        busy_high = 1'b1;
        for (int k = 0; k < n; k++) begin
          if (k > 0) @(negedge clk);
          if (!rst_n) begin
            aborted = 1'b1;
            break;
          end
          samp[k] = get_line(w);
          if (get_ready(w)) ready_low = 1'b0;
          if (!get_busy(w)) busy_high = 1'b0;
        end
        if (!aborted) begin
          uniform = 1'b1;
          word    = '0;
          for (int s = 0; s < dw + 2; s++)
            for (int j = 0; j < cpb; j++)
              if (samp[s*cpb + j] !== samp[s*cpb]) uniform = 1'b0;
          if (samp[0] !== 1'b0) uniform = 1'b0;
          if (samp[(dw+1)*cpb] !== 1'b1) uniform = 1'b0;
          for (int b = 0; b < dw; b++) word[b] = samp[(b+1)*cpb];
          if (get_qsize(w) == 0) begin
            check({p, "_unexpected_frame"}, get_qsize(w), 1);
          end else begin
            e = (w == 0) ? q_a.pop_front() : q_b.pop_front();
            check({p, "_frame_data"}, word, e.data);
            check({p, "_frame_shape"}, uniform, 1);
            check({p, "_ready_low_in_frame"}, ready_low, 1);
            check({p, "_busy_high_in_frame"}, busy_high, 1);
            if (e.gap >= 0) check({p, "_idle_gap"}, start_cyc - last_end - 1, e.gap);
          end
          last_end = cyc;
          @(negedge clk);
          if (rst_n) check({p, "_frame_end_line_ready"}, {get_line(w), get_ready(w)}, 2'b11);
        end
      end
    end
  endtask

  initial run_monitor(0, DW_A, CPB_A);
  initial run_monitor(1, DW_B, CPB_B);

  // Returns just after the posedge that accepted the word on the chosen DUT.
  task automatic wait_accept(input int w, input string name);
    bit ok;
    ok = 1'b0;
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      if (get_ready(w)) begin
        ok = 1'b1;
        break;
      end
    end
    check({name, "_accept"}, ok, 1);
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(input int w, input string name);
    bit ok;
    ok = 1'b0;
    for (int n = 0; n < 400; n++) begin
      @(negedge clk);
      if (get_qsize(w) == 0 && get_ready(w)) begin
        ok = 1'b1;
        break;
      end
    end
    check({name, "_done"}, ok, 1);
    repeat (4) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n   = 1'b0;
    data_a  = 8'h00;
    valid_a = 1'b0;
    data_b  = 5'h00;
    valid_b = 1'b0;

    // Reset values, then 20 idle cycles.
    repeat (3) @(posedge clk);
    #1;
    check("reset_a_line_ready_busy", {line_a, ready_a, busy_a}, 3'b110);
    check("reset_b_line_ready_busy", {line_b, ready_b, busy_b}, 3'b110);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("idle_a", {line_a, ready_a, busy_a}, 3'b110);
    end

    // Single frame 0xA5.
    @(posedge clk);
    #1;
    data_a  = 8'hA5;
    valid_a = 1'b1;
    q_a.push_back('{data: 16'h00A5, gap: -1});
    wait_accept(0, "a5");
    valid_a = 1'b0;
    data_a  = 8'h00;
    wait_done(0, "a5");

    // Back-to-back 0x00 then 0xFF with data changing mid-frame.
    @(posedge clk);
    #1;
    data_a  = 8'h00;
    valid_a = 1'b1;
    q_a.push_back('{data: 16'h0000, gap: -1});
    wait_accept(0, "b2b_first");
    data_a = 8'hFF;
    q_a.push_back('{data: 16'h00FF, gap: 1});
    wait_accept(0, "b2b_second");
    valid_a = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    data_a = 8'h12;
    wait_done(0, "b2b");

    // Valid pulse while busy must be ignored.
    @(posedge clk);
    #1;
    data_a  = 8'h5A;
    valid_a = 1'b1;
    q_a.push_back('{data: 16'h005A, gap: -1});
    wait_accept(0, "ignore");
    valid_a = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    data_a  = 8'h3C;
    valid_a = 1'b1;
    @(posedge clk);
    #1;
    valid_a = 1'b0;
    wait_done(0, "ignore");
    repeat (60) @(negedge clk);
    check("ignore_no_extra_frame", q_a.size(), 0);

    // Reset during data bit 3 of 0xC3, then a clean 0x81 frame.
    @(posedge clk);
    #1;
    data_a  = 8'hC3;
    valid_a = 1'b1;
    wait_accept(0, "rst_frame");
    valid_a = 1'b0;
    repeat (17) @(posedge clk);
    #2;
    check("bit3_line_before_reset", {line_a, busy_a}, 2'b01);
    rst_n = 1'b0;
    #1;
    check("async_reset_line_ready_busy", {line_a, ready_a, busy_a}, 3'b110);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("after_reset_idle", {line_a, ready_a, busy_a}, 3'b110);
    @(posedge clk);
    #1;
    data_a  = 8'h81;
    valid_a = 1'b1;
    q_a.push_back('{data: 16'h0081, gap: -1});
    wait_accept(0, "post_rst");
    valid_a = 1'b0;
    wait_done(0, "post_rst");

    // DATA_W=5, CLKS_PER_BIT=2 instance: 0x15 in a 14-cycle frame.
    @(posedge clk);
    #1;
    data_b  = 5'h15;
    valid_b = 1'b1;
    q_b.push_back('{data: 16'h0015, gap: -1});
    wait_accept(1, "small");
    valid_b = 1'b0;
    wait_done(1, "small");

    repeat (20) @(negedge clk);
    check("queue_a_drained", q_a.size(), 0);
    check("queue_b_drained", q_b.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
